multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath. It supports R-type, ori, lw, sw, beq and j.
- It replaces the single-cycle opcode decoder and drives all datapath enables and muxes state by state.
- It handshakes with a shared instruction/data memory that may insert wait states.
- It sits between the instruction register and the PC/register-file/ALU/memory muxes.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_TIMEOUT, 255, max wait cycles per memory access before fault; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  leave IDLE and begin fetching
Op_i  in  6  opcode from instruction register
mem_ready_i  in  1  memory access completes this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load if ALU zero
IorD_o  out  1  memory address: 0=PC, 1=ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  load instruction register
RegDst_o  out  1  1=rd, 0=rt
MemtoReg_o  out  1  1=MDR, 0=ALUOut
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0=PC, 1=reg A
ALUSrcB_o  out  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2
ALUOp_o  out  2  00=or, 01=add, 10=sub, 11=funct decode
ExtOp_o  out  1  1=sign-extend, 0=zero-extend
PCSource_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
busy_o  out  1  high in every state except IDLE and HALT
fault_o  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky
state_o  out  4  current state encoding
instr_cnt_o  out  CNT_W  retired instructions

Behaviour:
- Reset:
  - State becomes IDLE asynchronously.
  - All outputs are 0, including fault_o and instr_cnt_o.
  - The wait counter clears.
- Encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ORI_EXEC=11, ORI_WB=12, HALT=13. Codes 14–15 go to HALT.
- Signals not listed for a state are driven 0.
- IDLE: waits for start_i=1, then goes to FETCH.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=01, PCSource=00.
  - IRWrite and PCWrite are Mealy outputs: asserted only in the cycle mem_ready_i=1, which also moves the FSM to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=01, ExtOp=1 (branch target into ALUOut). Next state by Op_i:
  - 000000 → R_EXEC
  - 001101 → ORI_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → HALT with fault_o=01
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=01, ExtOp=1. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Holds until mem_ready_i, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retires; goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until mem_ready_i, then retires; goes to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=11. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Retires; goes to FETCH.
- ORI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=0. Goes to ORI_WB.
- ORI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Retires; goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCWriteCond=1, PCSource=01. Retires; goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Retires; goes to FETCH.
- HALT: all control outputs 0. Held until rst_i; start_i is ignored.
- Retire:
  - instr_cnt_o increments by 1 on each retire transition.
  - It wraps from all-ones to 0 silently.
  - Faulting instructions do not count.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEM_READ or MEM_WRITE with mem_ready_i=0.
  - Clears on state change.
  - With MEM_TIMEOUT>0, reaching MEM_TIMEOUT waiting cycles moves the FSM to HALT next cycle with fault_o=10.
  - If mem_ready_i=1 arrives in the same cycle the count reaches MEM_TIMEOUT, ready wins: the access completes and there is no fault.
- Latency with zero memory wait: R-type/ori/lw 4–5 cycles (lw 5), sw 4, beq 3, j 3.
- busy_o = state not IDLE and not HALT.
- Reset mid-access: the FSM returns to IDLE immediately and drops MemRead/MemWrite. No partial retire is counted.

Test Plan:
- Reset then start_i pulse, mem_ready_i tied 1, Op_i=000000 → states 1,2,7,8,1; RegWrite=RegDst=1 only in R_WB; instr_cnt_o=1 after 4 cycles.
- lw (100011) with mem_ready_i low 3 cycles in MEM_READ → MemRead/IorD=1 held 4 cycles; MEM_WB asserts RegWrite+MemtoReg; total 8 cycles; count +1.
- beq (000100) then j (000010) → BRANCH: PCWriteCond=1, ALUOp=10, PCSource=01; JUMP: PCWrite=1, PCSource=10; count +2 in 6 cycles.
- Op_i=111111 at DECODE → HALT (13), fault_o=01, busy_o=0, count unchanged; start_i ignored until rst_i.
- MEM_TIMEOUT=4, mem_ready_i=0 in FETCH → HALT after 4 wait cycles, fault_o=10; repeat with ready on 4th cycle → DECODE, no fault.
- CNT_W=4, 16 consecutive j instructions → instr_cnt_o wraps to 0; rst_i asserted mid-MEM_WRITE → MemWrite_o=0 same cycle, state_o=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for a MIPS-subset datapath
// (R-type, ori, lw, sw, beq, j). Control outputs decode the current state,
// with IRWrite/PCWrite in FETCH also gated by memory ready.
module multicycle_control #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       Op_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             RegDst_o,
    output logic             MemtoReg_o,
    output logic             RegWrite_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic             ExtOp_o,
    output logic [1:0]       PCSource_o,
    output logic             busy_o,
    output logic [1:0]       fault_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_ORI_EXEC  = 4'd11;
    localparam logic [3:0] S_ORI_WB    = 4'd12;
    localparam logic [3:0] S_HALT      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

    logic [3:0]        state_q, state_d;
    logic [1:0]        fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              retire;
    logic              timed_out;

    // This cycle would be the MEM_TIMEOUT-th consecutive wait cycle
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // State, fault, retire counter and wait counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            fault_q <= F_NONE;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, control decode, wait/timeout and retire logic
    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        wait_d        = '0;
        retire        = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegDst_o      = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        ExtOp_o       = 1'b0;
        PCSource_o    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALUOp_o   = 2'b01;
                if (mem_ready_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    state_d   = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    fault_d = F_TIMEOUT;
                end else begin
                    wait_d = WAIT_W'(wait_q + 1'b1);
                end
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                ALUOp_o   = 2'b01;
                ExtOp_o   = 1'b1;
                case (Op_i)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_ORI:       state_d = S_ORI_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        fault_d = F_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = 2'b01;
                ExtOp_o   = 1'b1;
                state_d   = (Op_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ, S_MEM_WRITE: begin
                IorD_o     = 1'b1;
                MemRead_o  = (state_q == S_MEM_READ);
                MemWrite_o = (state_q == S_MEM_WRITE);
                if (mem_ready_i) begin
                    if (state_q == S_MEM_READ) begin
                        state_d = S_MEM_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = S_HALT;
                    fault_d = F_TIMEOUT;
                end else begin
                    wait_d = WAIT_W'(wait_q + 1'b1);
                end
            end
            S_MEM_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b11;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_ORI_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = S_ORI_WB;
            end
            S_ORI_WB: begin
                RegWrite_o = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b10;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        cnt_d = retire ? CNT_W'(cnt_q + 1'b1) : cnt_q;
    end

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign fault_o     = fault_q;
    assign state_o     = state_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one default-parameter instance and
// one with CNT_W=4, MEM_TIMEOUT=4, both driven from the same inputs.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] op;
    logic       rdy;

    int tests = 0;
    int fails = 0;

    // Control vector: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    // RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB[2],ALUOp[2],ExtOp,PCSource[2]
    localparam logic [16:0] C_ZERO      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_0_00;
    localparam logic [16:0] C_FETCH     = 17'b0_0_0_1_0_0_0_0_0_0_01_01_0_00;
    localparam logic [16:0] C_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_01_0_00;
    localparam logic [16:0] C_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_01_1_00;
    localparam logic [16:0] C_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_01_1_00;
    localparam logic [16:0] C_MEM_READ  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_0_00;
    localparam logic [16:0] C_MEM_WB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_0_00;
    localparam logic [16:0] C_MEM_WRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_0_00;
    localparam logic [16:0] C_R_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_11_0_00;
    localparam logic [16:0] C_R_WB      = 17'b0_0_0_0_0_0_1_0_1_0_00_00_0_00;
    localparam logic [16:0] C_ORI_EXEC  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_0_00;
    localparam logic [16:0] C_ORI_WB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_0_00;
    localparam logic [16:0] C_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_10_0_01;
    localparam logic [16:0] C_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_0_10;

    logic pcw_a, pcwc_a, iord_a, mr_a, mw_a, irw_a, rd_a, m2r_a, rw_a, srca_a, ext_a, busy_a;
    logic [1:0] srcb_a, aluop_a, pcsrc_a, fault_a;
    logic [3:0] st_a;
    logic [15:0] cnt_a;
    logic pcw_b, pcwc_b, iord_b, mr_b, mw_b, irw_b, rd_b, m2r_b, rw_b, srca_b, ext_b, busy_b;
    logic [1:0] srcb_b, aluop_b, pcsrc_b, fault_b;
    logic [3:0] st_b;
    logic [3:0] cnt_b;
    logic [16:0] ctrl_a, ctrl_b;

    assign ctrl_a = {pcw_a, pcwc_a, iord_a, mr_a, mw_a, irw_a, rd_a, m2r_a, rw_a,
                     srca_a, srcb_a, aluop_a, ext_a, pcsrc_a};
    assign ctrl_b = {pcw_b, pcwc_b, iord_b, mr_b, mw_b, irw_b, rd_b, m2r_b, rw_b,
                     srca_b, srcb_b, aluop_b, ext_b, pcsrc_b};

    multicycle_control dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .mem_ready_i(rdy),
        .PCWrite_o(pcw_a), .PCWriteCond_o(pcwc_a), .IorD_o(iord_a), .MemRead_o(mr_a),
        .MemWrite_o(mw_a), .IRWrite_o(irw_a), .RegDst_o(rd_a), .MemtoReg_o(m2r_a),
        .RegWrite_o(rw_a), .ALUSrcA_o(srca_a), .ALUSrcB_o(srcb_a), .ALUOp_o(aluop_a),
        .ExtOp_o(ext_a), .PCSource_o(pcsrc_a), .busy_o(busy_a), .fault_o(fault_a),
        .state_o(st_a), .instr_cnt_o(cnt_a)
    );

    multicycle_control #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .mem_ready_i(rdy),
        .PCWrite_o(pcw_b), .PCWriteCond_o(pcwc_b), .IorD_o(iord_b), .MemRead_o(mr_b),
        .MemWrite_o(mw_b), .IRWrite_o(irw_b), .RegDst_o(rd_b), .MemtoReg_o(m2r_b),
        .RegWrite_o(rw_b), .ALUSrcA_o(srca_b), .ALUSrcB_o(srcb_b), .ALUOp_o(aluop_b),
        .ExtOp_o(ext_b), .PCSource_o(pcsrc_b), .busy_o(busy_b), .fault_o(fault_b),
        .state_o(st_b), .instr_cnt_o(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 6'b000000; rdy = 1'b1;
        #1;
        chk("reset_state", 32'(st_a), 32'd0);
        chk("reset_ctrl", 32'(ctrl_a), 32'(C_ZERO));
        chk("reset_fault", 32'(fault_a), 32'd0);
        chk("reset_cnt", 32'(cnt_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // R-type, zero wait
        start = 1'b1; #1;
        chk("idle_hold", 32'(st_a), 32'd0);
        tick(); start = 1'b0; #1;
        chk("r_fetch_state", 32'(st_a), 32'd1);
        chk("r_fetch_ctrl", 32'(ctrl_a), 32'(C_FETCH_RDY));
        chk("r_fetch_busy", 32'(busy_a), 32'd1);
        tick();
        chk("r_decode_state", 32'(st_a), 32'd2);
        chk("r_decode_ctrl", 32'(ctrl_a), 32'(C_DECODE));
        tick();
        chk("r_exec_state", 32'(st_a), 32'd7);
        chk("r_exec_ctrl", 32'(ctrl_a), 32'(C_R_EXEC));
        tick();
        chk("r_wb_state", 32'(st_a), 32'd8);
        chk("r_wb_ctrl", 32'(ctrl_a), 32'(C_R_WB));
        chk("r_wb_cnt", 32'(cnt_a), 32'd0);
        tick();
        chk("r_ret_state", 32'(st_a), 32'd1);
        chk("r_ret_cnt", 32'(cnt_a), 32'd1);

        // lw with three wait cycles in MEM_READ
        op = 6'b100011;
        tick();
        chk("lw_decode", 32'(st_a), 32'd2);
        tick();
        chk("lw_addr_state", 32'(st_a), 32'd3);
        chk("lw_addr_ctrl", 32'(ctrl_a), 32'(C_MEM_ADDR));
        rdy = 1'b0;
        tick();
        chk("lw_read1_state", 32'(st_a), 32'd4);
        chk("lw_read1_ctrl", 32'(ctrl_a), 32'(C_MEM_READ));
        tick();
        tick();
        chk("lw_read3_state", 32'(st_a), 32'd4);
        tick();
        rdy = 1'b1; #1;
        chk("lw_read4_ctrl", 32'(ctrl_a), 32'(C_MEM_READ));
        chk("lw_read4_b_state", 32'(st_b), 32'd4);
        tick();
        chk("lw_wb_state", 32'(st_a), 32'd5);
        chk("lw_wb_ctrl", 32'(ctrl_a), 32'(C_MEM_WB));
        chk("lw_ready_wins_b", 32'(st_b), 32'd5);
        tick();
        chk("lw_ret_cnt", 32'(cnt_a), 32'd2);
        chk("lw_ret_fault_b", 32'(fault_b), 32'd0);

        // beq then j
        op = 6'b000100;
        tick(); tick();
        chk("beq_state", 32'(st_a), 32'd9);
        chk("beq_ctrl", 32'(ctrl_a), 32'(C_BRANCH));
        tick();
        chk("beq_ret_cnt", 32'(cnt_a), 32'd3);
        op = 6'b000010;
        tick(); tick();
        chk("j_state", 32'(st_a), 32'd10);
        chk("j_ctrl", 32'(ctrl_a), 32'(C_JUMP));
        tick();
        chk("j_ret_state", 32'(st_a), 32'd1);
        chk("j_ret_cnt", 32'(cnt_a), 32'd4);

        // ori
        op = 6'b001101;
        tick(); tick();
        chk("ori_exec_state", 32'(st_a), 32'd11);
        chk("ori_exec_ctrl", 32'(ctrl_a), 32'(C_ORI_EXEC));
        tick();
        chk("ori_wb_state", 32'(st_a), 32'd12);
        chk("ori_wb_ctrl", 32'(ctrl_a), 32'(C_ORI_WB));
        tick();
        chk("ori_ret_cnt", 32'(cnt_a), 32'd5);

        // sw with one wait cycle
        op = 6'b101011;
        tick(); tick();
        rdy = 1'b0;
        tick();
        chk("sw_state", 32'(st_a), 32'd6);
        chk("sw_ctrl", 32'(ctrl_a), 32'(C_MEM_WRITE));
        tick();
        rdy = 1'b1; #1;
        chk("sw_hold_state", 32'(st_a), 32'd6);
        chk("sw_hold_cnt", 32'(cnt_a), 32'd5);
        tick();
        chk("sw_ret_state", 32'(st_a), 32'd1);
        chk("sw_ret_cnt", 32'(cnt_a), 32'd6);

        // illegal opcode
        op = 6'b111111;
        tick(); tick();
        chk("ill_state", 32'(st_a), 32'd13);
        chk("ill_fault", 32'(fault_a), 32'd1);
        chk("ill_busy", 32'(busy_a), 32'd0);
        chk("ill_ctrl", 32'(ctrl_a), 32'(C_ZERO));
        chk("ill_cnt", 32'(cnt_a), 32'd6);
        start = 1'b1;
        tick(); tick();
        chk("halt_ignores_start", 32'(st_a), 32'd13);
        chk("halt_fault_sticky", 32'(fault_a), 32'd1);
        start = 1'b0;
        rst = 1'b1; #1;
        chk("rst_from_halt_state", 32'(st_a), 32'd0);
        chk("rst_from_halt_fault", 32'(fault_a), 32'd0);
        chk("rst_from_halt_cnt", 32'(cnt_a), 32'd0);
        tick();
        rst = 1'b0;

        // FETCH timeout on the MEM_TIMEOUT=4 instance
        start = 1'b1; rdy = 1'b0;
        tick(); start = 1'b0; #1;
        chk("to_fetch_ctrl", 32'(ctrl_b), 32'(C_FETCH));
        tick(); tick(); tick();
        chk("to_fetch4_state", 32'(st_b), 32'd1);
        tick();
        chk("to_halt_state", 32'(st_b), 32'd13);
        chk("to_halt_fault", 32'(fault_b), 32'd2);
        chk("to_halt_busy", 32'(busy_b), 32'd0);
        chk("to_default_waits", 32'(st_a), 32'd1);
        chk("to_default_nofault", 32'(fault_a), 32'd0);
        rst = 1'b1; #1;
        tick();
        rst = 1'b0;

        // Ready on the 4th waiting cycle completes the fetch
        op = 6'b000010; start = 1'b1; rdy = 1'b0;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        rdy = 1'b1; #1;
        chk("to_rdy4_ctrl", 32'(ctrl_b), 32'(C_FETCH_RDY));
        tick();
        chk("to_rdy4_state", 32'(st_b), 32'd2);
        chk("to_rdy4_fault", 32'(fault_b), 32'd0);

        // 16 jumps: 4-bit counter wraps
        tick();
        chk("wrap_jump_ctrl", 32'(ctrl_b), 32'(C_JUMP));
        tick();
        chk("wrap_cnt1", 32'(cnt_b), 32'd1);
        for (int i = 0; i < 14; i++) begin
            tick(); tick(); tick();
        end
        chk("wrap_cnt15", 32'(cnt_b), 32'd15);
        tick(); tick(); tick();
        chk("wrap_cnt0", 32'(cnt_b), 32'd0);
        chk("wrap_cnt16_a", 32'(cnt_a), 32'd16);

        // Reset in the middle of a store
        op = 6'b101011;
        tick(); tick();
        rdy = 1'b0;
        tick();
        chk("mid_sw_memwrite", 32'(mw_a), 32'd1);
        chk("mid_sw_state", 32'(st_a), 32'd6);
        #2;
        rst = 1'b1; #1;
        chk("mid_rst_memwrite", 32'(mw_a), 32'd0);
        chk("mid_rst_state", 32'(st_a), 32'd0);
        chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
        chk("mid_rst_memwrite_b", 32'(mw_b), 32'd0);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
